// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage request/response bundle between EX/MEM and the data memory responder
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] MEM_Alu;
  logic [WIDTH-1:0] MEM_RegisterData2;
  logic [2:0]       MEM_Funct3;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic [WIDTH-1:0] MEM_Data;
  logic             MEM_Misaligned;

  modport master (
    output MEM_Alu,
    output MEM_RegisterData2,
    output MEM_Funct3,
    output MEM_MemRead,
    output MEM_MemWrite,
    input  MEM_Data,
    input  MEM_Misaligned
  );

  modport slave (
    input  MEM_Alu,
    input  MEM_RegisterData2,
    input  MEM_Funct3,
    input  MEM_MemRead,
    input  MEM_MemWrite,
    output MEM_Data,
    output MEM_Misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data memory with byte-lane stores and registered, extended loads
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic             store_legal;
  logic             load_legal;
  logic             suppress;
  logic             do_write;
  logic             do_load;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       wbe;
  logic [WIDTH-1:0] rword;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] data_q;
  logic             unused_addr;

  // Upper address bits wrap away; only the word index and lane bits matter.
  assign idx         = bus.MEM_Alu[AW+1:2];
  assign unused_addr = ^bus.MEM_Alu[WIDTH-1:AW+2];

  // Lane is forced to the natural alignment of the access size.
  always_comb begin
    lane = 2'b00;
    case (bus.MEM_Funct3[1:0])
      2'b00:   lane = bus.MEM_Alu[1:0];
      2'b01:   lane = {bus.MEM_Alu[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  always_comb begin
    store_legal = 1'b0;
    case (bus.MEM_Funct3)
      F3_B, F3_H, F3_W: store_legal = 1'b1;
      default:          store_legal = 1'b0;
    endcase
  end

  always_comb begin
    load_legal = 1'b0;
    case (bus.MEM_Funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: load_legal = 1'b1;
      default:                        load_legal = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned_req;
  logic mis_q;

  // A simultaneous read and write is treated as a store, so the store decides legality.
  always_comb begin
    misaligned_req = 1'b0;
    if (bus.MEM_MemWrite ? store_legal : (bus.MEM_MemRead && load_legal)) begin
      case (bus.MEM_Funct3[1:0])
        2'b01:   misaligned_req = bus.MEM_Alu[0];
        2'b10:   misaligned_req = (bus.MEM_Alu[1:0] != 2'b00);
        default: misaligned_req = 1'b0;
      endcase
    end
  end

  assign suppress = misaligned_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= misaligned_req;
    end
  end

  assign bus.MEM_Misaligned = mis_q;
`else
  assign suppress           = 1'b0;
  assign bus.MEM_Misaligned = 1'b0;
`endif

  assign do_write = reset && bus.MEM_MemWrite && store_legal && !suppress;
  assign do_load  = bus.MEM_MemRead && !bus.MEM_MemWrite && !suppress;

  // Store data is replicated across lanes; the byte enables pick the target lane.
  always_comb begin
    wdata = '0;
    wbe   = 4'b0000;
    case (bus.MEM_Funct3)
      F3_B: begin
        wdata = {4{bus.MEM_RegisterData2[7:0]}};
        wbe   = 4'b0001 << lane;
      end
      F3_H: begin
        wdata = {2{bus.MEM_RegisterData2[15:0]}};
        wbe   = 4'b0011 << lane;
      end
      F3_W: begin
        wdata = bus.MEM_RegisterData2;
        wbe   = 4'b1111;
      end
      default: begin
        wdata = '0;
        wbe   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rword    = mem[idx];
  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (bus.MEM_Funct3)
      F3_B:    load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_H:    load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   load_val = {{(WIDTH-16){1'b0}}, half_sel};
      F3_W:    load_val = rword;
      default: load_val = '0;
    endcase
  end

  // Registered read provides the one-cycle load latency MEM/WB depends on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (do_load) begin
      data_q <= load_val;
    end
  end

  assign bus.MEM_Data = data_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (either DMEM_MISALIGN_TRAP_EN setting)
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   req_id = 0;

  logic [31:0] exp_data_q [$];
  logic        exp_mis_q  [$];
  int          exp_id_q   [$];

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101, ILL = 3'b011;

  data_mem_responder_if #(.WIDTH(32)) bus ();

  data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one request for the next edge and queue what must be seen after it.
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_m);
    bus.MEM_MemRead       = rd;
    bus.MEM_MemWrite      = wr;
    bus.MEM_Funct3        = f3;
    bus.MEM_Alu           = addr;
    bus.MEM_RegisterData2 = wd;
    @(posedge clk);
    exp_data_q.push_back(exp_d);
    exp_mis_q.push_back(exp_m);
    exp_id_q.push_back(req_id);
    req_id++;
    #1;
    bus.MEM_MemRead  = 1'b0;
    bus.MEM_MemWrite = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_data_q.size() > 0) begin
        logic [31:0] ed;
        logic        em;
        int          id;
        ed = exp_data_q.pop_front();
        em = exp_mis_q.pop_front();
        id = exp_id_q.pop_front();
        check($sformatf("req%0d_data", id), bus.MEM_Data, ed);
        check($sformatf("req%0d_misaligned", id), {31'b0, bus.MEM_Misaligned}, {31'b0, em});
      end
    end
  end

  initial begin
    logic [31:0] after_mis;
    bus.MEM_MemRead       = 1'b0;
    bus.MEM_MemWrite      = 1'b0;
    bus.MEM_Funct3        = 3'b000;
    bus.MEM_Alu           = '0;
    bus.MEM_RegisterData2 = '0;
    #1;
    check("reset_data", bus.MEM_Data, 32'h0);
    check("reset_misaligned", {31'b0, bus.MEM_Misaligned}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    req(0, 1, W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req(1, 0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Mid-cycle asynchronous reset, with a store presented while it is held.
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_data", bus.MEM_Data, 32'h0);
    bus.MEM_MemWrite      = 1'b1;
    bus.MEM_Funct3        = W;
    bus.MEM_Alu           = 32'h10;
    bus.MEM_RegisterData2 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    check("reset_held_data", bus.MEM_Data, 32'h0);
    bus.MEM_MemWrite = 1'b0;
    reset = 1'b1;
    req(1, 0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    req(0, 1, W,  32'h10, 32'h0,  32'hDEADBEEF, 1'b0);
    req(0, 1, B,  32'h13, 32'h80, 32'hDEADBEEF, 1'b0);
    req(1, 0, B,  32'h13, 32'h0,  32'hFFFFFF80, 1'b0);
    req(1, 0, BU, 32'h13, 32'h0,  32'h00000080, 1'b0);
    req(1, 0, W,  32'h10, 32'h0,  32'h80000000, 1'b0);

    req(0, 1, W,  32'h20, 32'hA5A5A5A5, 32'h80000000, 1'b0);
    req(0, 1, H,  32'h22, 32'h8001,     32'h80000000, 1'b0);
    req(1, 0, H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0);
    req(1, 0, HU, 32'h22, 32'h0,        32'h00008001, 1'b0);
    req(1, 0, W,  32'h20, 32'h0,        32'h8001A5A5, 1'b0);
    req(1, 0, BU, 32'h21, 32'h0,        32'h000000A5, 1'b0);
    req(0, 0, W,  32'h20, 32'h0,        32'h000000A5, 1'b0);

    req(0, 1, W, 32'h10, 32'h12345678, 32'h000000A5, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    req(1, 0, W, 32'h11, 32'h0,        32'h000000A5, 1'b1);
    req(0, 1, W, 32'h12, 32'hFFFFFFFF, 32'h000000A5, 1'b1);
    req(1, 0, W, 32'h10, 32'h0,        32'h12345678, 1'b0);
    after_mis = 32'h12345678;
`else
    req(1, 0, W, 32'h11, 32'h0,        32'h12345678, 1'b0);
    req(0, 1, W, 32'h12, 32'hFFFFFFFF, 32'h12345678, 1'b0);
    req(1, 0, W, 32'h10, 32'h0,        32'hFFFFFFFF, 1'b0);
    after_mis = 32'hFFFFFFFF;
`endif

    req(0, 1, W,   32'h1004, 32'hCAFEF00D, after_mis,    1'b0);
    req(1, 0, W,   32'h4,    32'h0,        32'hCAFEF00D, 1'b0);
    req(0, 0, W,   32'h4,    32'h0,        32'hCAFEF00D, 1'b0);
    req(1, 0, ILL, 32'h4,    32'h0,        32'h0,        1'b0);
    req(0, 1, ILL, 32'h4,    32'h11111111, 32'h0,        1'b0);
    req(1, 0, W,   32'h4,    32'h0,        32'hCAFEF00D, 1'b0);
    req(1, 1, W,   32'h4,    32'h0BADBEEF, 32'hCAFEF00D, 1'b0);
    req(1, 0, W,   32'h4,    32'h0,        32'h0BADBEEF, 1'b0);

    for (int i = 0; i < 20 && exp_data_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_data_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_data_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the MEM stage of the 5-stage RISC-V pipeline: it receives the MEM-stage load/store request and returns load data one cycle later.
- It sits behind the EX/MEM register and in front of the MEM/WB register. Its registered read output supplies the one-cycle delay that the MEM/WB stage relies on for load data.
- It performs store byte-lane masking, load byte/half extraction with sign or zero extension, and optional misaligned-access trapping.

## Interface
Parameters:
- WIDTH, 32, data and address width; only 32 is supported.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MEM_Alu  input  WIDTH  byte address.
- MEM_RegisterData2  input  WIDTH  store data, right-aligned.
- MEM_Funct3  input  3  access size and sign.
- MEM_MemRead  input  1  load request, this cycle.
- MEM_MemWrite  input  1  store request, this cycle.
- MEM_Data  output  WIDTH  registered, extended load result; feeds WB_Data.
- MEM_Misaligned  output  1  registered one-cycle fault pulse.

## Operation
- Storage: DEPTH_WORDS x 32, little-endian.
  - Word index = MEM_Alu[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - Array contents are not reset.
- Stores (MEM_MemWrite=1) are selected by MEM_Funct3:
  - 000 SB: byte lane MEM_Alu[1:0] <= Data2[7:0].
  - 001 SH: half lane MEM_Alu[1] <= Data2[15:0].
  - 010 SW: whole word.
  - Any other funct3: no write.
- Loads (MEM_MemRead=1) are selected by MEM_Funct3:
  - 000 LB: byte, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 001 LH: half, sign-extended.
  - 101 LHU: half, zero-extended.
  - 010 LW: whole word.
  - 011/110/111: MEM_Data <= 0.
- Lane selection uses the same address bits as stores.
- MEM_MemRead and MEM_MemWrite both high: the store is performed and MEM_Data holds.
- Neither request high: MEM_Data holds its previous value and no write occurs.
- Alignment rule: a halfword access is misaligned when MEM_Alu[0]=1; a word access is misaligned when MEM_Alu[1:0]!=0. Byte accesses are never misaligned.

## Timing
- Reset asserted (reset=0): MEM_Data=0 and MEM_Misaligned=0 immediately, asynchronously.
- While reset=0, array writes are inhibited, including a store presented on the same edge.
- Load latency is 1 cycle: a request sampled at edge N appears on MEM_Data after edge N and stays stable through the WB cycle.
- Store commits at the sampling edge. A load to the same word on the following cycle returns the new data.
- There is no same-cycle read/write conflict, because only one request exists per cycle.
- MEM_Misaligned asserts for exactly the one cycle following the offending request edge. Otherwise it is 0.
- There are no stalls or backpressure; the block accepts one request every cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A misaligned load or store is suppressed: no array write, and MEM_Data holds.
  - MEM_Misaligned pulses high for one cycle.
- DMEM_MISALIGN_TRAP_EN undefined:
  - MEM_Misaligned is tied to 0.
  - Misaligned accesses are forced aligned: LH/LHU/SH ignore MEM_Alu[0]; LW/SW ignore MEM_Alu[1:0].
  - The access then proceeds normally.

## Test plan
- Reset and word round trip:
  - Stimulus: reset=0 mid-cycle, then SW 0xDEADBEEF to 0x10; next cycle LW 0x10.
  - Required: MEM_Data=0 during reset; MEM_Data=0xDEADBEEF one cycle after the load edge.
- Byte store and byte loads:
  - Stimulus: SB 0x80 to 0x13 over a word of 0; then LB 0x13; then LBU 0x13.
  - Required: LB returns 0xFFFFFF80; LBU returns 0x00000080; LW 0x10 returns 0x80000000.
- Halfword loads:
  - Stimulus: SH 0x8001 to 0x22; then LH 0x22 and LHU 0x22.
  - Required: LH returns 0xFFFF8001; LHU returns 0x00008001; bytes 0x20/0x21 are unchanged.
- Misaligned word access:
  - Stimulus: LW 0x11 after SW 0x12345678 to 0x10.
  - Required with the macro: MEM_Misaligned=1 for one cycle and MEM_Data holds.
  - Required without the macro: MEM_Data=0x12345678.
- Hold, wrap, illegal funct3 and reset-inhibited store:
  - Stimulus: an idle cycle after a load.
  - Required: MEM_Data is unchanged.
  - Stimulus: SW to address 4*DEPTH_WORDS+4, then LW 0x4.
  - Required: the load returns the stored value (address wrap).
  - Stimulus: a load with funct3=011.
  - Required: MEM_Data=0.
  - Stimulus: a store presented while reset=0.
  - Required: the word is unmodified.
